// File: rtl/nes_pkg.sv
// Shared constants and state type for the NES pad responder.
package nes_pkg;

   localparam int NES_FRAME_BITS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } nes_pad_state_t;

endpackage

// File: rtl/nes_pad_responder_sync_ff.sv
// Multi-stage synchronizer for asynchronous single-bit inputs.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/nes_pad_responder.sv
// NES pad responder: latches buttons and shifts them out to the host.
// Optional turbo on A/B is built only when NES_TURBO_EN is defined.
module nes_pad_responder
   import nes_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter bit DATA_ACTIVE_LOW = 1'b1,
   parameter int TURBO_FRAMES    = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [7:0] buttons,
   input  logic [1:0] turbo_en,
   input  logic       nes_latch,
   input  logic       nes_clk,
   output logic       nes_data,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [3:0] LAST_BIT = 4'(NES_FRAME_BITS - 1);

   nes_pad_state_t state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           data_q;
   logic           fd_q, fd_d;
   logic           lat_s, clk_s;
   logic           lat_prev_q, clk_prev_q;
   logic           lat_fall, clk_rise;
   logic [7:0]     btn_m;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lat (
      .clk_i  (CLK),
      .rst_ni (reset),
      .d_i    (nes_latch),
      .q_o    (lat_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk_i  (CLK),
      .rst_ni (reset),
      .d_i    (nes_clk),
      .q_o    (clk_s)
   );

   assign lat_fall = lat_prev_q & ~lat_s;
   assign clk_rise = clk_s & ~clk_prev_q;

`ifdef NES_TURBO_EN
   localparam int TW = $clog2(TURBO_FRAMES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TURBO_FRAMES - 1);

   logic [TW-1:0] tcnt_q;
   logic          phase_q;

   // One latch frame is counted when the host releases latch.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         tcnt_q  <= '0;
         phase_q <= 1'b0;
      end else if (lat_fall && state_q == LOAD) begin
         if (tcnt_q == TLAST) begin
            tcnt_q  <= '0;
            phase_q <= ~phase_q;
         end else begin
            tcnt_q <= tcnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      btn_m        = buttons;
      btn_m[BTN_A] = buttons[BTN_A] & ~(turbo_en[0] & ~phase_q);
      btn_m[BTN_B] = buttons[BTN_B] & ~(turbo_en[1] & ~phase_q);
   end
`else
   logic unused_turbo;
   assign unused_turbo = ^{turbo_en, TURBO_FRAMES[0]};
   assign btn_m = buttons;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      fd_d    = 1'b0;
      // Latch level has priority over any serial clock edge.
      if (lat_s) begin
         state_d = LOAD;
         cnt_d   = '0;
         shift_d = btn_m;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (lat_fall) begin
                  state_d = SHIFT;
                  cnt_d   = '0;
               end
            end
            SHIFT: begin
               if (clk_rise) begin
                  shift_d = {1'b1, shift_q[7:1]};
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == LAST_BIT) begin
                     state_d = DONE;
                     fd_d    = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         data_q     <= DATA_ACTIVE_LOW;
         fd_q       <= 1'b0;
         lat_prev_q <= 1'b0;
         clk_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         data_q     <= shift_d[0] ^ DATA_ACTIVE_LOW;
         fd_q       <= fd_d;
         lat_prev_q <= lat_s;
         clk_prev_q <= clk_s;
      end
   end

   assign nes_data   = data_q;
   assign busy       = (state_q == SHIFT);
   assign frame_done = fd_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder.
module tb_nes_pad_responder;

   localparam int   S   = 2;
   localparam int   PH  = S + 3;
   localparam logic DAL = 1'b1;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] buttons = '0;
   logic [1:0] turbo_en = '0;
   logic       nes_latch = 1'b0;
   logic       nes_clk = 1'b0;
   logic       nes_data, busy, frame_done;

   int checks = 0;
   int failures = 0;
   int fd_seen = 0;

   logic exp_q[$];

   typedef struct {
      logic [7:0] btn;
      logic [7:0] wire_exp;
   } vec_t;

   vec_t tbl[4];

   nes_pad_responder #(
      .SYNC_STAGES     (S),
      .DATA_ACTIVE_LOW (1'b1),
      .TURBO_FRAMES    (2)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .buttons    (buttons),
      .turbo_en   (turbo_en),
      .nes_latch  (nes_latch),
      .nes_clk    (nes_clk),
      .nes_data   (nes_data),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (frame_done) fd_seen++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic latch_pulse(input logic [7:0] b, input int ph);
      buttons   = b;
      nes_latch = 1'b1;
      cyc(ph);
      nes_latch = 1'b0;
      cyc(ph);
   endtask

   task automatic clk_pulse(input int ph);
      nes_clk = 1'b1;
      cyc(ph);
      nes_clk = 1'b0;
      cyc(ph);
   endtask

   // Host view of a frame: bit i of the word, then pressed level forever.
   task automatic model_frame(input logic [7:0] b, input int n);
      exp_q.delete();
      for (int i = 0; i < 8; i++)
         exp_q.push_back(b[i] ? ~DAL : DAL);
      for (int i = 0; i < n; i++)
         exp_q.push_back(~DAL);
   endtask

   initial begin
      int f0, lat_c, fd_c, n, ph;
      logic [7:0] b;
      logic [7:0] turbo_exp;

      tbl[0] = '{btn: 8'h85, wire_exp: 8'h7A};
      tbl[1] = '{btn: 8'h00, wire_exp: 8'hFF};
      tbl[2] = '{btn: 8'hFF, wire_exp: 8'h00};
      tbl[3] = '{btn: 8'h5A, wire_exp: 8'hA5};

      cyc(3);
      chk("rst_data", nes_data, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fd", frame_done, 0);
      reset = 1'b1;
      cyc(10);
      chk("idle_data", nes_data, 1);
      chk("idle_busy", busy, 0);
      chk("idle_fd", fd_seen, 0);

      // Table frames; row 0 is followed by over-clocking.
      for (int r = 0; r < 4; r++) begin
         f0 = fd_seen;
         latch_pulse(tbl[r].btn, PH);
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl%0d_bit%0d", r, i), nes_data,
                tbl[r].wire_exp[i]);
            if (i == 0) chk($sformatf("tbl%0d_busy", r), busy, 1);
            clk_pulse(PH);
         end
         chk($sformatf("tbl%0d_fill", r), nes_data, 0);
         chk($sformatf("tbl%0d_done", r), fd_seen - f0, 1);
         chk($sformatf("tbl%0d_idle", r), busy, 0);
         if (r == 0) begin
            for (int k = 0; k < 4; k++) begin
               clk_pulse(PH);
               chk($sformatf("over%0d", k), nes_data, 0);
            end
            chk("over_done", fd_seen - f0, 1);
         end
      end

      // Abort after 3 shifts; counter must restart.
      latch_pulse(8'h00, PH);
      repeat (3) clk_pulse(PH);
      f0 = fd_seen;
      latch_pulse(8'h01, PH);
      chk("abort_a", nes_data, 0);
      repeat (7) clk_pulse(PH);
      chk("abort_nodone", fd_seen - f0, 0);
      chk("abort_busy", busy, 1);
      clk_pulse(PH);
      chk("abort_done", fd_seen - f0, 1);

      // Latch and serial clock rise together mid-frame.
      latch_pulse(8'h00, PH);
      repeat (2) clk_pulse(PH);
      model_frame(8'h85, 7);
      buttons   = 8'h85;
      nes_latch = 1'b1;
      nes_clk   = 1'b1;
      cyc(PH);
      nes_latch = 1'b0;
      cyc(PH);
      nes_clk = 1'b0;
      cyc(PH);
      chk("cont_bit0", nes_data, exp_q.pop_front());
      chk("cont_busy", busy, 1);
      for (int k = 1; k < 8; k++) begin
         clk_pulse(PH);
         chk($sformatf("cont_bit%0d", k), nes_data, exp_q.pop_front());
      end

      // Edge-to-data latency and frame_done alignment on the 8th shift.
      latch_pulse(8'h00, PH);
      repeat (7) clk_pulse(PH);
      lat_c = 0;
      fd_c  = 0;
      nes_clk = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         if (nes_data == 1'b0 && lat_c == 0) lat_c = c;
         if (frame_done && fd_c == 0) fd_c = c;
      end
      nes_clk = 1'b0;
      cyc(PH);
      chk("latency", lat_c, S + 1);
      chk("fd_align", fd_c, S + 1);

      // Asynchronous reset mid-frame.
      latch_pulse(8'h00, PH);
      repeat (2) clk_pulse(PH);
      chk("pre_rst_busy", busy, 1);
      @(negedge CLK);
      #2 reset = 1'b0;
      #1;
      chk("arst_data", nes_data, 1);
      chk("arst_busy", busy, 0);
      chk("arst_fd", frame_done, 0);
      cyc(2);
      reset = 1'b1;
      cyc(4);
      chk("post_rst_busy", busy, 0);

`ifdef NES_TURBO_EN
      turbo_exp = 8'b0011_0011;
      turbo_en  = 2'b01;
      for (int f = 0; f < 8; f++) begin
         latch_pulse(8'h01, PH);
         chk($sformatf("turbo%0d", f), nes_data, turbo_exp[f]);
      end
      turbo_en = 2'b00;
`else
      turbo_exp = 8'h00;
`endif

      // Randomized frames against the queue model.
      for (int f = 0; f < 20; f++) begin
         b  = 8'($urandom);
         n  = $urandom_range(11, 0);
         ph = $urandom_range(S + 5, S + 2);
`ifndef NES_TURBO_EN
         turbo_en = 2'($urandom);
`endif
         model_frame(b, n);
         f0 = fd_seen;
         latch_pulse(b, ph);
         chk($sformatf("rnd%0d_b0", f), nes_data, exp_q.pop_front());
         for (int k = 1; k <= n; k++) begin
            clk_pulse(ph);
            chk($sformatf("rnd%0d_b%0d", f, k), nes_data,
                exp_q.pop_front());
         end
         chk($sformatf("rnd%0d_done", f), fd_seen - f0, (n >= 8) ? 1 : 0);
         chk($sformatf("rnd%0d_busy", f), busy, (n < 8) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
